digit_shadow_sequencer: RTL and testbench



---
 rtl/digit_seq_pkg.sv | 41 ++++
 rtl/digit_shadow_sequencer_if.sv | 12 +
 rtl/digit_bank.sv | 50 +++++
 rtl/digit_shadow_sequencer.sv | 134 +++++++++++++
 tb/tb_digit_shadow_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/digit_seq_pkg.sv
// Shared types and constants for the digit shadow sequencer: FSM states,
// blank tile code, RTC register indices and BCD nibble helpers.
package digit_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    GAP,
    SWAP
  } seq_state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam int REG_HOUR = 0;
  localparam int REG_MIN  = 1;
  localparam int REG_SEC  = 2;
  localparam int REG_DAY  = 3;
  localparam int REG_MON  = 4;
  localparam int REG_YEAR = 5;
  localparam int REG_TH   = 6;
  localparam int REG_TM   = 7;
  localparam int REG_TS   = 8;

  function automatic logic nibble_ok(input logic [3:0] n);
    return n <= 4'd9;
  endfunction

  function automatic logic bcd_ok(input logic [7:0] b);
    return nibble_ok(b[7:4]) && nibble_ok(b[3:0]);
  endfunction

  // Invalid nibbles become BLANK_CODE so the renderer shows an empty tile
  function automatic logic [7:0] bcd_sanitize(input logic [7:0] b);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = nibble_ok(b[7:4]) ? b[7:4] : BLANK_CODE;
    lo = nibble_ok(b[3:0]) ? b[3:0] : BLANK_CODE;
    return {hi, lo};
  endfunction

endpackage

// File: rtl/digit_shadow_sequencer_if.sv
// RTC register read port: req/ack handshake, data valid with ack.
interface digit_shadow_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [7:0]        rd_data;

  modport master (output rd_req, output rd_addr, input rd_ack, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_ack, output rd_data);
endinterface

// File: rtl/digit_bank.sv
// Double-buffered BCD register file: shadow written per RTC read, copied to
// the active bank on swap; active bank feeds a registered tile lookup.
module digit_bank
  import digit_seq_pkg::*;
#(
  parameter int NUM_REGS = 9,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic             swap,
  input  logic [4:0]       tile_idx,
  output logic [3:0]       tile_code
);

  logic [7:0]       shadow [NUM_REGS];
  logic [7:0]       active [NUM_REGS];
  logic [IDX_W-1:0] sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (we) shadow[wr_idx] <= wr_data;
      if (swap) begin
        for (int i = 0; i < NUM_REGS; i++) active[i] <= shadow[i];
      end
    end
  end

  // Even tiles show tens, odd tiles show units of register tile_idx/2
  assign sel = IDX_W'(tile_idx >> 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tile_code <= '0;
    end else if (int'(tile_idx) >= 2 * NUM_REGS) begin
      tile_code <= BLANK_CODE;
    end else begin
      tile_code <= tile_idx[0] ? active[sel][3:0] : active[sel][7:4];
    end
  end

endmodule

// File: rtl/digit_shadow_sequencer.sv
// Per-frame RTC snapshot sequencer feeding the digit-tile renderer.
// Optional DIGIT_BCD_CHECK_EN: blank invalid nibbles and report bcd_err.
module digit_shadow_sequencer
  import digit_seq_pkg::*;
#(
  parameter int                NUM_REGS  = 9,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h21,
  parameter int                TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  digit_shadow_sequencer_if.master rtc,
  input  logic [4:0]               tile_idx,
  output logic [3:0]               tile_code,
  output logic                     busy,
  output logic                     fetch_done,
  output logic                     snap_err
`ifdef DIGIT_BCD_CHECK_EN
  ,
  output logic                     bcd_err
`endif
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  seq_state_t       state, state_next;
  logic [IDX_W-1:0] index, index_next;
  logic [CNT_W-1:0] tmo_cnt, cnt_next;
  logic             shadow_we;
  logic             swap;
  logic             abort;
  logic [7:0]       wr_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      index      <= '0;
      tmo_cnt    <= '0;
      fetch_done <= 1'b0;
      snap_err   <= 1'b0;
    end else begin
      state      <= state_next;
      index      <= index_next;
      tmo_cnt    <= cnt_next;
      fetch_done <= swap;
      if (abort)     snap_err <= 1'b1;
      else if (swap) snap_err <= 1'b0;
    end
  end

  // The timeout counter holds the number of READ cycles already spent unacked
  always_comb begin
    state_next = state;
    index_next = index;
    cnt_next   = '0;
    shadow_we  = 1'b0;
    swap       = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_tick) begin
          index_next = '0;
          state_next = READ;
        end
      end
      READ: begin
        if (rtc.rd_ack) begin
          shadow_we = 1'b1;
          if (index == IDX_W'(NUM_REGS - 1)) begin
            state_next = SWAP;
          end else begin
            index_next = index + 1'b1;
            state_next = GAP;
          end
        end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
          abort      = 1'b1;
          index_next = '0;
          state_next = IDLE;
        end else begin
          cnt_next = tmo_cnt + 1'b1;
        end
      end
      GAP: state_next = READ;
      SWAP: begin
        swap       = 1'b1;
        index_next = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rtc.rd_req  = (state == READ);
  assign rtc.rd_addr = BASE_ADDR + ADDR_W'(index);
  assign busy        = (state != IDLE);

`ifdef DIGIT_BCD_CHECK_EN
  logic snap_bad;

  assign wr_data = bcd_sanitize(rtc.rd_data);

  // snap_bad collects invalid nibbles across one snapshot; published at SWAP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_bad <= 1'b0;
      bcd_err  <= 1'b0;
    end else begin
      if (state == IDLE && frame_tick)      snap_bad <= 1'b0;
      else if (shadow_we && !bcd_ok(rtc.rd_data)) snap_bad <= 1'b1;
      if (swap) bcd_err <= snap_bad;
    end
  end
`else
  assign wr_data = rtc.rd_data;
`endif

  digit_bank #(
    .NUM_REGS(NUM_REGS),
    .IDX_W   (IDX_W)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .we       (shadow_we),
    .wr_idx   (index),
    .wr_data  (wr_data),
    .swap     (swap),
    .tile_idx (tile_idx),
    .tile_code(tile_code)
  );

endmodule

// File: tb/tb_digit_shadow_sequencer.sv
// Directed bench for digit_shadow_sequencer with an RTC responder model and
// address/tile scoreboards.
module tb_digit_shadow_sequencer;
  import digit_seq_pkg::*;

  localparam int NUM_REGS = 9;
  localparam int BASE     = 'h21;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic [4:0] tile_idx;
  logic [3:0] tile_code;
  logic       busy;
  logic       fetch_done;
  logic       snap_err;
`ifdef DIGIT_BCD_CHECK_EN
  logic       bcd_err;
`endif

  digit_shadow_sequencer_if #(.ADDR_W(8)) rtc_if ();

  digit_shadow_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .rtc       (rtc_if),
    .tile_idx  (tile_idx),
    .tile_code (tile_code),
    .busy      (busy),
    .fetch_done(fetch_done),
    .snap_err  (snap_err)
`ifdef DIGIT_BCD_CHECK_EN
    ,
    .bcd_err   (bcd_err)
`endif
  );

  int         tests_run    = 0;
  int         tests_failed = 0;
  int         ack_latency  = 3;
  int         drop_idx     = -1;
  int         drop_cycles  = 0;
  int         req_age      = 0;
  int         fetch_cnt    = 0;
  int         exp_fetch    = 0;
  int         cycles;
  int         drop_start;
  logic       fd_end;
  logic [7:0] rtc_mem  [NUM_REGS];
  logic [7:0] good_mem [NUM_REGS];
  logic [7:0] exp_addr_q [$];
  logic [3:0] exp_tile_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // RTC model: acks ack_latency cycles into each request, never acks drop_idx
  always @(negedge clk) begin
    if (reset) begin
      rtc_if.rd_ack  = 1'b0;
      rtc_if.rd_data = 8'h00;
      req_age        = 0;
    end else if (rtc_if.rd_ack) begin
      rtc_if.rd_ack = 1'b0;
      req_age       = 0;
    end else if (rtc_if.rd_req) begin
      if (drop_idx >= 0 && int'(rtc_if.rd_addr) == BASE + drop_idx) begin
        drop_cycles++;
      end else if (req_age >= ack_latency) begin
        rtc_if.rd_ack  = 1'b1;
        rtc_if.rd_data = rtc_mem[int'(rtc_if.rd_addr) - BASE];
        if (exp_addr_q.size() == 0) checkOutput("addr_unexpected", rtc_if.rd_addr, 0);
        else                        checkOutput("rd_addr", rtc_if.rd_addr, exp_addr_q.pop_front());
        req_age = 0;
      end else begin
        req_age++;
      end
    end else begin
      req_age = 0;
    end
  end

  always @(negedge clk) if (fetch_done) fetch_cnt++;

  function automatic logic [3:0] tileModel(input int t);
    logic [7:0] b;
    logic [3:0] n;
    if (t >= 2 * NUM_REGS) return BLANK_CODE;
    b = good_mem[t / 2];
    n = (t % 2 == 0) ? b[7:4] : b[3:0];
`ifdef DIGIT_BCD_CHECK_EN
    if (n > 4'd9) n = BLANK_CODE;
`endif
    return n;
  endfunction

  // One frame: pulse frame_tick, optionally re-pulse it mid-snapshot, wait idle
  task automatic applyStimulus(input int lat, input int drop, input int extra_tick_at,
                               output int n_cycles, output logic fd_last);
    ack_latency = lat;
    drop_idx    = drop;
    for (int i = 0; i < NUM_REGS; i++)
      if (drop < 0 || i < drop) exp_addr_q.push_back(8'(BASE + i));
    @(negedge clk);
    frame_tick = 1'b1;
    n_cycles   = 0;
    do begin
      @(negedge clk);
      n_cycles++;
      frame_tick = (n_cycles == extra_tick_at);
    end while (busy && n_cycles < 600);
    frame_tick = 1'b0;
    fd_last    = fetch_done;
    checkOutput("snapshot_bound", 32'(n_cycles < 600), 1);
    drop_idx = -1;
  endtask

  task automatic checkTiles(input string tag);
    int t;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (exp_tile_q.size() > 0) checkOutput(tag, tile_code, exp_tile_q.pop_front());
      if (i < 20) begin
        t = (i < 18) ? i : ((i == 18) ? 18 : 31);
        tile_idx = 5'(t);
        exp_tile_q.push_back(tileModel(t));
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    tile_idx   = '0;
    for (int i = 0; i < NUM_REGS; i++) good_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_rd_req", rtc_if.rd_req, 0);
    checkOutput("rst_rd_addr", rtc_if.rd_addr, 'h21);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_fetch_done", fetch_done, 0);
    checkOutput("rst_snap_err", snap_err, 0);
    checkOutput("rst_tile_code", tile_code, 0);
    reset = 1'b0;

    rtc_mem[REG_HOUR] = 8'h12; rtc_mem[REG_MIN]  = 8'h34; rtc_mem[REG_SEC] = 8'h56;
    rtc_mem[REG_DAY]  = 8'h07; rtc_mem[REG_MON]  = 8'h09; rtc_mem[REG_YEAR] = 8'h24;
    rtc_mem[REG_TH]   = 8'h01; rtc_mem[REG_TM]   = 8'h02; rtc_mem[REG_TS]  = 8'h03;
    applyStimulus(3, -1, 0, cycles, fd_end);
    exp_fetch++;
    checkOutput("normal_fetch_done", fd_end, 1);
    checkOutput("normal_snap_err", snap_err, 0);
    good_mem = rtc_mem;
    checkTiles("tile_normal");
    checkOutput("normal_fetch_count", fetch_cnt, exp_fetch);

    for (int i = 0; i < NUM_REGS; i++) rtc_mem[i] = 8'((i + 1) * 8'h11);
    drop_start = drop_cycles;
    applyStimulus(1, 3, 0, cycles, fd_end);
    checkOutput("timeout_snap_err", snap_err, 1);
    checkOutput("timeout_fetch_done", fd_end, 0);
    checkOutput("timeout_cycles", drop_cycles - drop_start, 255);
    checkTiles("tile_after_timeout");
    checkOutput("timeout_fetch_count", fetch_cnt, exp_fetch);

    applyStimulus(2, -1, 0, cycles, fd_end);
    exp_fetch++;
    checkOutput("clean_snap_err", snap_err, 0);
    checkOutput("clean_fetch_done", fd_end, 1);
    good_mem = rtc_mem;
    checkTiles("tile_clean");

    rtc_mem[REG_HOUR] = 8'h23; rtc_mem[REG_MIN]  = 8'h59; rtc_mem[REG_SEC] = 8'h58;
    rtc_mem[REG_DAY]  = 8'h31; rtc_mem[REG_MON]  = 8'h12; rtc_mem[REG_YEAR] = 8'h99;
    rtc_mem[REG_TH]   = 8'h00; rtc_mem[REG_TM]   = 8'h45; rtc_mem[REG_TS]  = 8'h10;
    applyStimulus(0, -1, 7, cycles, fd_end);
    exp_fetch++;
    checkOutput("min_length_cycles", cycles, 2 * NUM_REGS + 1);
    checkOutput("min_fetch_done", fd_end, 1);
    repeat (40) @(negedge clk);
    checkOutput("extra_tick_busy", busy, 0);
    checkOutput("extra_tick_fetch_count", fetch_cnt, exp_fetch);
    good_mem = rtc_mem;
    checkTiles("tile_min");

`ifdef DIGIT_BCD_CHECK_EN
    rtc_mem[REG_HOUR] = 8'h3A;
    applyStimulus(1, -1, 0, cycles, fd_end);
    exp_fetch++;
    checkOutput("bcd_err_set", bcd_err, 1);
    good_mem = rtc_mem;
    checkTiles("tile_bcd");
    rtc_mem[REG_HOUR] = 8'h12;
    applyStimulus(1, -1, 0, cycles, fd_end);
    exp_fetch++;
    checkOutput("bcd_err_clear", bcd_err, 0);
    good_mem = rtc_mem;
`endif

    ack_latency = 50;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midread_rd_req", rtc_if.rd_req, 1);
    checkOutput("midread_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("reset_rd_req", rtc_if.rd_req, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rd_addr", rtc_if.rd_addr, 'h21);
    checkOutput("reset_tile_code", tile_code, 0);
    checkOutput("reset_fetch_done", fetch_done, 0);
    checkOutput("reset_snap_err", snap_err, 0);
`ifdef DIGIT_BCD_CHECK_EN
    checkOutput("reset_bcd_err", bcd_err, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) good_mem[i] = 8'h00;
    checkTiles("tile_after_reset");
    checkOutput("addr_queue_drained", exp_addr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
